// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage sequencer (READ/EXEC/WB) owning the 8x16 register file in front of the ALU
module alu_exec_ctrl #(
    parameter int DATA_W  = 16,
    parameter int OPC_W   = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_ovf,
    input  logic              host_we,
    input  logic [2:0]        host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic [2:0]        cap_q, cap_d, fl_q, fl_d;
    logic              ready_q, ready_d, done_q, done_d;
    logic [2:0]        rd;
    logic              unused_bits;
    assign rd          = instr_q[11:9];
    assign unused_bits = ^instr_q[2:0];
    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        instr_d = instr_q;
        a_d     = a_q;
        b_d     = b_q;
        opc_d   = opc_q;
        res_d   = res_q;
        cap_d   = cap_q;
        fl_d    = fl_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host_we && !(R0_ZERO && host_addr == 3'd0))
                    regs_d[host_addr] = host_data;
                if (instr_valid && ready_q) begin
                    instr_d = instr;
                    state_d = READ;
                end
            end
            READ: begin
                a_d     = regs_q[instr_q[8:6]];
                b_d     = regs_q[instr_q[5:3]];
                opc_d   = OPC_W'(instr_q[15:12]);
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_out;
                cap_d   = {alu_zero, alu_neg, alu_ovf};
                state_d = WB;
            end
            WB: begin
                if (!(R0_ZERO && rd == 3'd0))
                    regs_d[rd] = res_q;
                fl_d    = cap_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
        ready_d = state_d == IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            regs_q  <= '{default: '0};
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opc_q   <= '0;
            res_q   <= '0;
            cap_q   <= '0;
            fl_q    <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            res_q   <= res_d;
            cap_q   <= cap_d;
            fl_q    <= fl_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end
    assign instr_ready = ready_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = opc_q;
    assign dbg_data    = (R0_ZERO && dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];
    assign {flag_z, flag_n, flag_v} = fl_q;
    assign done        = done_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: random and directed instruction streams checked against a register-array model
module tb_alu_exec_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_opcode;
    logic        alu_zero, alu_neg, alu_ovf;
    logic        host_we = 1'b0;
    logic [2:0]  host_addr = '0;
    logic [15:0] host_data = '0;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
    logic        flag_z, flag_n, flag_v, done;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m [8];
    logic [2:0]  mf;

    alu_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: returns {zero, neg, ovf, result}
    function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        logic [15:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            4'd0:        begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd1, 4'd15: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd2:        r = a & b;
            4'd3:        r = a | b;
            4'd4:        r = a ^ b;
            4'd5:        r = a << b[3:0];
            4'd6:        r = a >> b[3:0];
            default:     r = (a * 16'd3 + b) ^ {12'd0, op};
        endcase
        return {r == 16'd0, r[15], v, r};
    endfunction

    assign {alu_zero, alu_neg, alu_ovf, alu_out} = alu_f(alu_a, alu_b, alu_opcode);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset;
        for (int i = 0; i < 8; i++) m[i] = '0;
        mf = '0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk(tag, dbg_data, m[i]);
        end
        chk({tag, "_flags"}, {flag_z, flag_n, flag_v}, mf);
    endtask

    task automatic hwrite(input logic [2:0] a, input logic [15:0] d);
        host_we = 1'b1; host_addr = a; host_data = d;
        tick;
        host_we = 1'b0;
        if (a != 3'd0) m[a] = d;
    endtask

    // mode 0: normal, 1: reset during EXEC, 2: host write to R1 during EXEC
    task automatic issue(input logic [15:0] ins, input int mode, input logic hw, input logic [2:0] ha,
                         input logic [15:0] hd, input logic nv, input logic [15:0] ni);
        logic [2:0]  rd, r1, r2;
        logic [15:0] ea, eb;
        logic [18:0] f;
        rd = ins[11:9]; r1 = ins[8:6]; r2 = ins[5:3];
        chk("rdy_idle", instr_ready, 1);
        instr = ins; instr_valid = 1'b1;
        host_we = hw; host_addr = ha; host_data = hd;
        if (hw && ha != 3'd0) m[ha] = hd;
        ea = m[r1]; eb = m[r2];
        f = alu_f(ea, eb, ins[15:12]);
        tick;
        instr_valid = nv; instr = ni; host_we = 1'b0;
        chk("rdy_read", instr_ready, 0);
        tick;
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_opcode, ins[15:12]);
        chk("rdy_exec", instr_ready, 0);
        if (mode == 1) begin
            rst_n = 1'b0;
            tick;
            chk("done_rst", done, 0);
            chk("rdy_rst", instr_ready, 0);
            tick;
            rst_n = 1'b1;
            model_reset();
            tick;
            chk("rdy_after_rst", instr_ready, 1);
            chk("done_after_rst", done, 0);
            return;
        end
        if (mode == 2) begin
            host_we = 1'b1; host_addr = 3'd1; host_data = 16'h1234;
        end
        tick;
        host_we = 1'b0;
        dbg_addr = rd;
        chk("done_wb", done, 0);
        chk("rdy_wb", instr_ready, 0);
        tick;
        if (rd != 3'd0) m[rd] = f[15:0];
        mf = f[18:16];
        chk("done", done, 1);
        chk("rdy_done", instr_ready, 1);
        chk("wb_reg", dbg_data, m[rd]);
        chk("flags", {flag_z, flag_n, flag_v}, mf);
    endtask

    initial begin
        model_reset();
        tick;
        tick;
        chk("rdy_in_rst", instr_ready, 0);
        chk("alu_a_rst", alu_a, 0);
        chk("alu_op_rst", alu_opcode, 0);
        rst_n = 1'b1;
        tick;
        chk("rdy_post_rst", instr_ready, 1);
        chk("done_post_rst", done, 0);
        check_all("reset");
        // Reset wipes previously written registers
        for (int i = 0; i < 8; i++) hwrite(3'(i), 16'($urandom));
        check_all("hw_pre");
        rst_n = 1'b0;
        tick;
        chk("rdy_rst_a", instr_ready, 0);
        tick;
        chk("rdy_rst_b", instr_ready, 0);
        model_reset();
        check_all("rst_clear");
        rst_n = 1'b1;
        tick;
        chk("rdy_rel", instr_ready, 1);
        hwrite(3'd1, 16'd7);
        hwrite(3'd2, 16'd5);
        issue(16'hF650, 0, 0, 0, 0, 0, 0);
        dbg_addr = 3'd3;
        #1 chk("r3_is_2", dbg_data, 16'h0002);
        issue(16'h10D8, 0, 0, 0, 0, 0, 0);
        chk("z_on_rd0", flag_z, 1);
        hwrite(3'd0, 16'hFFFF);
        check_all("r0_drop");
        issue(16'h0A50, 0, 0, 0, 0, 1, 16'h4D58);
        issue(16'h4D58, 0, 0, 0, 0, 0, 0);
        issue(16'h0850, 1, 0, 0, 0, 0, 0);
        check_all("mid_rst");
        hwrite(3'd1, 16'h0055);
        issue(16'h0448, 2, 0, 0, 0, 0, 0);
        check_all("hw_exec_ignored");
        issue(16'h0650, 0, 1, 3'd1, 16'h00AA, 0, 0);
        chk("r1_aa", m[1], 16'h00AA);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                issue(16'($urandom), 0, 1, 3'($urandom_range(0, 7)), 16'($urandom), 0, 0);
            else
                issue(16'($urandom), 0, 0, 0, 0, 0, 0);
        end
        check_all("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
